// File: rtl/event_counter_bank.sv
// event_counter_bank: bank of up/down event counters with clear, load, wrap/saturate limits and limit-event flags
module event_counter_bank #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int STATE_W = 3,
  parameter logic [STATE_W-1:0] COUNT_STATE = '0,
  parameter int SATURATE = 0,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STATE_W-1:0]        state,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH*CHANNELS-1:0] load_val,
  output logic [WIDTH*CHANNELS-1:0] count,
  output logic [CHANNELS-1:0]       at_max,
  output logic [CHANNELS-1:0]       at_zero,
  output logic [CHANNELS-1:0]       lim_pulse,
  output logic [CHANNELS-1:0]       ovf_sticky
);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] UP_LIMIT = SATURATE != 0 ? MAX_W : '0;
  localparam logic [WIDTH:0] DN_LIMIT = SATURATE != 0 ? '0 : MAX_W;
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0] lim_d, stk_d;
  logic [WIDTH:0] cur, lv, stepped, nxt;
  logic en, step, hit;
  assign en = state == COUNT_STATE;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_out
    assign count[i*WIDTH +: WIDTH] = cnt[i];
    assign at_max[i] = cnt[i] == MAX_W[WIDTH-1:0];
    assign at_zero[i] = cnt[i] == '0;
  end
  // next count and flags per channel: clr > load > qualified inc/dec
  always_comb begin
    cnt_d = cnt;
    lim_d = '0;
    stk_d = '0;
    cur = '0;
    lv = '0;
    stepped = '0;
    nxt = '0;
    step = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cur = {1'b0, cnt[i]};
      lv = {1'b0, load_val[i*WIDTH +: WIDTH]};
      step = en & (inc[i] ^ dec[i]);
      hit = step & (inc[i] ? cur == MAX_W : cur == '0);
      stepped = inc[i] ? cur + ONE : cur - ONE;
      nxt = load[i] ? (lv > MAX_W ? MAX_W : lv) : hit ? (inc[i] ? UP_LIMIT : DN_LIMIT) : step ? stepped : cur;
      cnt_d[i] = clr[i] ? '0 : nxt[WIDTH-1:0];
      lim_d[i] = ~clr[i] & ~load[i] & hit;
      stk_d[i] = ~clr[i] & (ovf_sticky[i] | lim_d[i]);
    end
  end
  // state registers with synchronous reset overriding all strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '{default: '0};
      lim_pulse <= '0;
      ovf_sticky <= '0;
    end else begin
      cnt <= cnt_d;
      lim_pulse <= lim_d;
      ovf_sticky <= stk_d;
    end
  end
endmodule

// File: tb/tb_event_counter_bank.sv
// tb_event_counter_bank: checks three counter-bank configurations against a behavioural model
module tb_event_counter_bank;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] state;
  logic [3:0] inc, dec, clr, load;
  logic [15:0] load_val;
  logic [2:0][15:0] cnt_o;
  logic [2:0][3:0] amax_o, azero_o, lim_o, stk_o;
  int n_cmp = 0;
  int n_bad = 0;
  int maxv [3] = '{15, 9, 9};
  int satv [3] = '{0, 1, 0};
  int m_cnt [3][4];
  bit m_lim [3][4];
  bit m_stk [3][4];

  always #5 clk = ~clk;

  event_counter_bank d0 (
    .clk(clk), .reset(reset), .state(state), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_o[0]), .at_max(amax_o[0]), .at_zero(azero_o[0]),
    .lim_pulse(lim_o[0]), .ovf_sticky(stk_o[0])
  );
  event_counter_bank #(.SATURATE(1), .MAX_VAL(9)) d1 (
    .clk(clk), .reset(reset), .state(state), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_o[1]), .at_max(amax_o[1]), .at_zero(azero_o[1]),
    .lim_pulse(lim_o[1]), .ovf_sticky(stk_o[1])
  );
  event_counter_bank #(.SATURATE(0), .MAX_VAL(9)) d2 (
    .clk(clk), .reset(reset), .state(state), .inc(inc), .dec(dec), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_o[2]), .at_max(amax_o[2]), .at_zero(azero_o[2]),
    .lim_pulse(lim_o[2]), .ovf_sticky(stk_o[2])
  );

  typedef struct {
    bit rst;
    logic [2:0] st;
    logic [3:0] inc, dec, clr, ld;
    logic [15:0] lv;
    logic [15:0] e_cnt;
    logic [3:0] e_lim, e_stk;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int c, n;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        c = m_cnt[k][i];
        if (reset || clr[i]) begin
          m_cnt[k][i] = 0;
          m_lim[k][i] = 0;
          m_stk[k][i] = 0;
        end else if (load[i]) begin
          n = int'(load_val[i*4 +: 4]);
          m_cnt[k][i] = n > maxv[k] ? maxv[k] : n;
          m_lim[k][i] = 0;
        end else if (state == 3'b000 && inc[i] != dec[i]) begin
          n = inc[i] ? c + 1 : c - 1;
          m_lim[k][i] = (n > maxv[k]) || (n < 0);
          if (n > maxv[k]) n = satv[k] != 0 ? maxv[k] : 0;
          else if (n < 0) n = satv[k] != 0 ? 0 : maxv[k];
          if (m_lim[k][i]) m_stk[k][i] = 1;
          m_cnt[k][i] = n;
        end else m_lim[k][i] = 0;
      end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("d%0d.count[%0d]", k, i), int'(cnt_o[k][i*4 +: 4]), m_cnt[k][i]);
        chk($sformatf("d%0d.lim_pulse[%0d]", k, i), int'(lim_o[k][i]), int'(m_lim[k][i]));
        chk($sformatf("d%0d.ovf_sticky[%0d]", k, i), int'(stk_o[k][i]), int'(m_stk[k][i]));
        chk($sformatf("d%0d.at_max[%0d]", k, i), int'(amax_o[k][i]), int'(m_cnt[k][i] == maxv[k]));
        chk($sformatf("d%0d.at_zero[%0d]", k, i), int'(azero_o[k][i]), int'(m_cnt[k][i] == 0));
      end
  endtask

  task automatic drive(input bit r, input logic [2:0] st, input logic [3:0] i_inc, input logic [3:0] i_dec,
                       input logic [3:0] i_clr, input logic [3:0] i_ld, input logic [15:0] lv);
    reset = r;
    state = st;
    inc = i_inc;
    dec = i_dec;
    clr = i_clr;
    load = i_ld;
    load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    vec_t tbl [14];
    tbl[0]  = '{1'b1, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h1111, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h2222, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 3'd1, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h2222, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 3'd1, 4'hF, 4'h0, 4'h1, 4'h4, 16'h0700, 16'h2720, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 3'd0, 4'h0, 4'h8, 4'h0, 4'h0, 16'h0000, 16'h1720, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 3'd0, 4'h0, 4'h8, 4'h0, 4'h0, 16'h0000, 16'h0720, 4'h0, 4'h0};
    tbl[7]  = '{1'b0, 3'd0, 4'h0, 4'h8, 4'h0, 4'h0, 16'h0000, 16'h9720, 4'h8, 4'h8};
    tbl[8]  = '{1'b0, 3'd0, 4'h8, 4'h8, 4'h0, 4'h0, 16'h0000, 16'h9720, 4'h0, 4'h8};
    tbl[9]  = '{1'b0, 3'd0, 4'h1, 4'h0, 4'h1, 4'h3, 16'h00F5, 16'h9790, 4'h0, 4'h8};
    tbl[10] = '{1'b0, 3'd0, 4'h8, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0790, 4'h8, 4'h8};
    tbl[11] = '{1'b0, 3'd0, 4'h2, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0700, 4'h2, 4'hA};
    tbl[12] = '{1'b0, 3'd0, 4'h0, 4'h0, 4'h8, 4'h0, 16'h0000, 16'h0700, 4'h0, 4'h2};
    tbl[13] = '{1'b0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h2, 16'h0030, 16'h0730, 4'h0, 4'h2};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        m_cnt[k][i] = 0;
        m_lim[k][i] = 0;
        m_stk[k][i] = 0;
      end
    drive(1'b1, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    @(negedge clk);
    for (int v = 0; v < 14; v++) begin
      drive(tbl[v].rst, tbl[v].st, tbl[v].inc, tbl[v].dec, tbl[v].clr, tbl[v].ld, tbl[v].lv);
      tick();
      chk($sformatf("tbl%0d.count", v), int'(cnt_o[2]), int'(tbl[v].e_cnt));
      chk($sformatf("tbl%0d.lim_pulse", v), int'(lim_o[2]), int'(tbl[v].e_lim));
      chk($sformatf("tbl%0d.ovf_sticky", v), int'(stk_o[2]), int'(tbl[v].e_stk));
    end
    drive(1'b0, 3'd0, 4'h0, 4'h0, 4'hF, 4'h0, 16'h0);
    tick();
    for (int j = 0; j < 16; j++) begin
      drive(1'b0, 3'd0, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0);
      tick();
      if (j == 14) begin
        chk("wrap15.count0", int'(cnt_o[0][3:0]), 15);
        chk("wrap15.at_max0", int'(amax_o[0][0]), 1);
      end
      if (j == 15) begin
        chk("wrap16.count0", int'(cnt_o[0][3:0]), 0);
        chk("wrap16.lim0", int'(lim_o[0][0]), 1);
        chk("wrap16.stk0", int'(stk_o[0][0]), 1);
      end
    end
    drive(1'b0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    tick();
    chk("wrap_idle.lim0", int'(lim_o[0][0]), 0);
    chk("wrap_idle.stk0", int'(stk_o[0][0]), 1);
    drive(1'b0, 3'd0, 4'h0, 4'h0, 4'hF, 4'h0, 16'h0);
    tick();
    chk("wrap_clr.stk0", int'(stk_o[0][0]), 0);
    for (int j = 0; j < 12; j++) begin
      drive(1'b0, 3'd0, 4'h2, 4'h0, 4'h0, 4'h0, 16'h0);
      tick();
      chk($sformatf("sat%0d.count1", j + 1), int'(cnt_o[1][7:4]), j < 9 ? j + 1 : 9);
      chk($sformatf("sat%0d.lim1", j + 1), int'(lim_o[1][1]), int'(j >= 9));
    end
    chk("sat.at_max1", int'(amax_o[1][1]), 1);
    chk("sat.stk1", int'(stk_o[1][1]), 1);
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'd0,
            4'($urandom), 4'($urandom),
            4'($urandom & $urandom & $urandom & $urandom),
            4'($urandom & $urandom & $urandom),
            16'($urandom));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
